lpc_io_target: RTL

Parametrised LPC I/O-cycle target: decodes host I/O read/write cycles on the LPC bus, claims a configurable address window, and serves a byte-wide register file with per-register read-only (status) inputs. It replaces the fixed decoder/control/register/mux chain under the board top (ODS_MR). It is the single owner of the CPLD's LPC bus drivers.

---
 rtl/lpc_pkg.sv | 22 ++
 rtl/lpc_io_regfile.sv | 50 +++++
 rtl/lpc_io_target.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC definitions: target FSM states and the START/CYCTYPE/SYNC nibble encodings.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR
    } lpc_state_e;

    localparam logic [3:0] LPC_START      = 4'b0000;
    localparam logic [3:0] LPC_IO_RD      = 4'b0000;
    localparam logic [3:0] LPC_IO_WR      = 4'b0010;
    localparam logic [3:0] LPC_SYNC_READY = 4'b0000;
    localparam logic [3:0] LPC_SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] LPC_TAR        = 4'b1111;

endpackage

// File: rtl/lpc_io_regfile.sv
// Byte-wide register file behind the LPC target: RW storage, read-only status muxing,
// write commit and the write strobe/index reporting.
module lpc_io_regfile
    import lpc_pkg::*;
#(
    parameter int                  NUM_REGS = 32,
    parameter int                  IDXW     = 5,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [IDXW-1:0]       wr_idx_i,
    input  logic [7:0]            wr_data_i,
    input  logic [NUM_REGS*8-1:0] status_i,
    output logic [NUM_REGS*8-1:0] data_o,
    output logic                  wr_strobe_o,
    output logic [IDXW-1:0]       wr_index_o
);

    logic [7:0]      regs_q [NUM_REGS];
    logic            wr_strobe_q;
    logic [IDXW-1:0] wr_index_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            // Writes aimed at status registers are dropped silently.
            if (wr_en_i && !RO_MASK[wr_idx_i]) begin
                regs_q[wr_idx_i] <= wr_data_i;
                wr_strobe_q      <= 1'b1;
                wr_index_q       <= wr_idx_i;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_byte
        assign data_o[8*i +: 8] = RO_MASK[i] ? status_i[8*i +: 8] : regs_q[i];
    end

    assign wr_strobe_o = wr_strobe_q;
    assign wr_index_o  = wr_index_q;

endmodule

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target claiming a NUM_REGS-byte window at BASE_ADDR; sole driver of LAD.
// Define LPC_WAIT_SYNC_EN to insert WAIT_CYCLES long-wait SYNC nibbles before ready.
//
// state   | meaning
// IDLE    | waiting for START (LFRAME# low, LAD = 0000)
// CYCTYPE | decode I/O read / I/O write, anything else is ignored
// ADDR    | 4 address nibbles, MSB first; window check on the last one
// WDATA   | write data, low nibble then high nibble
// HTAR    | host turnaround, 2 cycles, bus not driven
// SYNC    | optional long-wait nibbles, then ready
// RDATA   | read data, low nibble then high nibble
// PTAR    | drive 1111 for one cycle, release for one cycle
module lpc_io_target
    import lpc_pkg::*;
#(
    parameter logic [15:0]         BASE_ADDR   = 16'h0800,
    parameter int                  NUM_REGS    = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK     = {NUM_REGS{1'b0}},
    parameter int                  WAIT_CYCLES = 2
) (
    input  logic                          LpcClock,
    input  logic                          PciReset,
    input  logic                          LpcFrame,
    inout  wire  [3:0]                    LpcBus,
    input  logic [NUM_REGS*8-1:0]         StatusIn,
    output logic [NUM_REGS*8-1:0]         DataReg,
    output logic                          WrStrobe,
    output logic [$clog2(NUM_REGS)-1:0]   WrIndex
);

    localparam int IDXW = $clog2(NUM_REGS);
`ifdef LPC_WAIT_SYNC_EN
    localparam bit LWAIT_EN = 1'b1;
`else
    localparam bit LWAIT_EN = 1'b0;
`endif
    localparam logic [3:0] N_WAIT = LWAIT_EN ? 4'(WAIT_CYCLES) : 4'd0;

    lpc_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rd_hold_q, rd_hold_d;
    logic        is_wr_q, is_wr_d;
    logic        bus_oe_q, bus_oe_d;
    logic [3:0]  bus_dat_q, bus_dat_d;
    logic        commit;
    logic [3:0]  lad_in;
    logic [15:0] addr_full;
    logic        claim;
    logic [7:0]  rd_byte;

    assign lad_in    = LpcBus;
    assign addr_full = {addr_q[11:0], lad_in};
    assign claim     = (addr_full[15:IDXW] == BASE_ADDR[15:IDXW]);
    assign rd_byte   = DataReg[8*int'(addr_full[IDXW-1:0]) +: 8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_hold_d = rd_hold_q;
        is_wr_d   = is_wr_q;
        commit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!LpcFrame && lad_in == LPC_START) state_d = ST_CYCTYPE;
            end
            ST_CYCTYPE: begin
                cnt_d = '0;
                if (!LpcFrame) begin
                    // START may be stretched; the last START nibble counts.
                    state_d = (lad_in == LPC_START) ? ST_CYCTYPE : ST_IDLE;
                end else if (lad_in == LPC_IO_RD) begin
                    is_wr_d = 1'b0;
                    state_d = ST_ADDR;
                end else if (lad_in == LPC_IO_WR) begin
                    is_wr_d = 1'b1;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                addr_d = addr_full;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    cnt_d     = '0;
                    rd_hold_d = rd_byte;
                    if (!claim)       state_d = ST_IDLE;
                    else if (is_wr_q) state_d = ST_WDATA;
                    else              state_d = ST_HTAR;
                end
            end
            ST_WDATA: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd0) begin
                    wdata_d[3:0] = lad_in;
                end else begin
                    wdata_d[7:4] = lad_in;
                    cnt_d        = '0;
                    state_d      = ST_HTAR;
                end
            end
            ST_HTAR: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (cnt_q != N_WAIT) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d   = '0;
                    commit  = is_wr_q;
                    state_d = is_wr_q ? ST_PTAR : ST_RDATA;
                end
            end
            ST_RDATA: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_PTAR;
                end
            end
            ST_PTAR: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Host abort: drop the cycle (and any pending write) and look for a new START now.
        if (!LpcFrame && state_q != ST_IDLE && state_q != ST_CYCTYPE) begin
            state_d = (lad_in == LPC_START) ? ST_CYCTYPE : ST_IDLE;
            commit  = 1'b0;
        end
    end

    always_comb begin
        bus_oe_d  = 1'b0;
        bus_dat_d = LPC_TAR;
        case (state_d)
            ST_SYNC: begin
                bus_oe_d  = 1'b1;
                bus_dat_d = (cnt_d != N_WAIT) ? LPC_SYNC_LWAIT : LPC_SYNC_READY;
            end
            ST_RDATA: begin
                bus_oe_d  = 1'b1;
                bus_dat_d = cnt_d[0] ? rd_hold_d[7:4] : rd_hold_d[3:0];
            end
            ST_PTAR: begin
                bus_oe_d  = (cnt_d == 4'd0);
                bus_dat_d = LPC_TAR;
            end
            default: begin
                bus_oe_d  = 1'b0;
                bus_dat_d = LPC_TAR;
            end
        endcase
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_hold_q <= '0;
            is_wr_q   <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_dat_q <= LPC_TAR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_hold_q <= rd_hold_d;
            is_wr_q   <= is_wr_d;
            bus_oe_q  <= bus_oe_d;
            bus_dat_q <= bus_dat_d;
        end
    end

    assign LpcBus = (bus_oe_q && LpcFrame) ? bus_dat_q : 4'bzzzz;

    lpc_io_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDXW     (IDXW),
        .RO_MASK  (RO_MASK)
    ) u_regfile (
        .clk_i       (LpcClock),
        .rst_n_i     (PciReset),
        .wr_en_i     (commit),
        .wr_idx_i    (addr_q[IDXW-1:0]),
        .wr_data_i   (wdata_q),
        .status_i    (StatusIn),
        .data_o      (DataReg),
        .wr_strobe_o (WrStrobe),
        .wr_index_o  (WrIndex)
    );

endmodule
